// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - PRBS Fibonacci generator with optional self-synchronising checker.
// Checker logic is compiled in only when PRBS_CHECKER_EN is defined.
module prbs_gen_chk #(
    parameter int              NB       = 9,
    parameter int              TAP      = 5,
    parameter logic [NB-1:0]   SEED     = 9'h1AA,
    parameter int              LANES    = 1,
    parameter int              LOCK_CNT = 16,
    parameter int              LOSS_CNT = 4,
    parameter int              ERR_W    = 16
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_enb_tx,
    output logic [LANES-1:0]   o_data,
    input  logic [LANES-1:0]   i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_clr_err,
    output logic               o_lock,
    output logic               o_err,
    output logic [ERR_W-1:0]   o_err_count
);

    localparam logic [NB-1:0] SEED_EFF = (SEED == '0) ? NB'(1) : SEED;

    logic [NB-1:0] r_gen;
    logic [NB-1:0] w_gen_next;

    always_comb begin
        w_gen_next = r_gen;
        for (int i = 0; i < LANES; i++) begin
            w_gen_next = {w_gen_next[NB-2:0], w_gen_next[NB-1] ^ w_gen_next[TAP-1]};
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_gen <= SEED_EFF;
        end else if (i_enable && i_enb_tx) begin
            r_gen <= w_gen_next;
        end
    end

    // The top LANES register bits are exactly the next LANES serial output bits.
    assign o_data = r_gen[NB-1 -: LANES];

`ifdef PRBS_CHECKER_EN
    localparam int CW = $clog2(LANES + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [NB-1:0]    r_hist;
    logic [NB-1:0]    w_hist_next;
    logic [GW-1:0]    r_good_cnt;
    logic [BW-1:0]    r_bad_cnt;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_err;
    logic [CW-1:0]    w_nerr;
    logic             w_pred;
    logic             w_act;
    logic             w_good;
    logic             w_word_err;
    logic [ERR_W:0]   w_sum;
    logic             w_lock;

    assign w_act = i_enable && i_rx_valid;

    // In SEARCH the history tracks the received bits; in LOCKED it free-runs on its own predictions.
    always_comb begin
        w_hist_next = r_hist;
        w_nerr      = '0;
        w_pred      = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_pred = w_hist_next[NB-1] ^ w_hist_next[TAP-1];
            if (w_pred != i_rx_data[LANES-1-i]) begin
                w_nerr = w_nerr + CW'(1);
            end
            w_hist_next = {w_hist_next[NB-2:0],
                           (r_state == S_LOCKED) ? w_pred : i_rx_data[LANES-1-i]};
        end
    end

    assign w_word_err = (w_nerr != '0);
    assign w_good     = !w_word_err && (r_hist != '0);
    assign w_sum      = {1'b0, r_err_cnt} + {{(ERR_W + 1 - CW){1'b0}}, w_nerr};

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_act) begin
            case (r_state)
                S_SEARCH: if (w_good && r_good_cnt == GW'(LOCK_CNT - 1)) w_state_next = S_LOCKED;
                S_LOCKED: if (w_word_err && r_bad_cnt == BW'(LOSS_CNT - 1)) w_state_next = S_SEARCH;
                default:  w_state_next = S_SEARCH;
            endcase
        end
    end

    always_comb begin
        w_lock = (r_state == S_LOCKED);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_hist     <= '0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_act && w_lock && w_word_err;
            if (w_act) begin
                r_hist <= w_hist_next;
                if (!w_lock) begin
                    r_bad_cnt <= '0;
                    if (!w_good || r_good_cnt == GW'(LOCK_CNT - 1)) r_good_cnt <= '0;
                    else                                             r_good_cnt <= r_good_cnt + GW'(1);
                end else begin
                    r_good_cnt <= '0;
                    if (!w_word_err || r_bad_cnt == BW'(LOSS_CNT - 1)) r_bad_cnt <= '0;
                    else                                                r_bad_cnt <= r_bad_cnt + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_err_cnt <= '0;
        end else if (i_clr_err) begin
            r_err_cnt <= '0;
        end else if (w_act && w_lock) begin
            r_err_cnt <= w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];
        end
    end

    assign o_lock      = w_lock;
    assign o_err       = r_err;
    assign o_err_count = r_err_cnt;
`else
    logic w_unused;
    assign w_unused    = ^{i_rx_data, i_rx_valid, i_clr_err, LOCK_CNT[0], LOSS_CNT[0]};
    assign o_lock      = 1'b0;
    assign o_err       = 1'b0;
    assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - scoreboard bench: LANES=1/ERR_W=3 and LANES=8 instances vs. a sequence model.
module tb_prbs_gen_chk;

`ifdef PRBS_CHECKER_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_n;
    logic       a_en, a_tx, a_rxv, a_clr, a_lock, a_err;
    logic [0:0] a_rxd, a_data;
    logic [2:0] a_cnt;
    logic       b_en, b_tx, b_rxv, b_clr, b_lock, b_err;
    logic [7:0] b_rxd, b_data;
    logic [15:0] b_cnt;

    prbs_gen_chk #(.LANES(1), .ERR_W(3)) u_a (
        .clock(clock), .i_reset(rst_n), .i_enable(a_en), .i_enb_tx(a_tx),
        .o_data(a_data), .i_rx_data(a_rxd), .i_rx_valid(a_rxv), .i_clr_err(a_clr),
        .o_lock(a_lock), .o_err(a_err), .o_err_count(a_cnt)
    );

    prbs_gen_chk #(.LANES(8)) u_b (
        .clock(clock), .i_reset(rst_n), .i_enable(b_en), .i_enb_tx(b_tx),
        .o_data(b_data), .i_rx_data(b_rxd), .i_rx_valid(b_rxv), .i_clr_err(b_clr),
        .o_lock(b_lock), .o_err(b_err), .o_err_count(b_cnt)
    );

    typedef struct {
        int dut;
        int data;
        int lock;
        int err;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: serial sequence s[], received/predicted bit history h[], lock bookkeeping.
    int   cur, lanes, step, good, badw, cnt, maxcnt;
    bit   lockd;
    bit   s[$];
    bit   h[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        logic [8:0] seed;
        seed   = 9'h1AA;
        cur    = d;
        lanes  = (d == 0) ? 1 : 8;
        maxcnt = (d == 0) ? 7 : 65535;
        step   = 0;
        good   = 0;
        badw   = 0;
        cnt    = 0;
        lockd  = 1'b0;
        h.delete();
        repeat (9) h.push_back(1'b0);
        s.delete();
        for (int i = 0; i < 9; i++) s.push_back(seed[8-i]);
    endtask

    // s_n = s_{n-9} ^ s_{n-5}; word j holds s[j*L .. j*L+L-1], oldest bit at the MSB.
    task automatic get_word(input int jj, output logic [7:0] w);
        int n;
        while (s.size() < (jj + 1) * lanes) begin
            n = s.size();
            s.push_back(s[n-9] ^ s[n-5]);
        end
        w = 8'h00;
        for (int i = 0; i < lanes; i++) w[lanes-1-i] = s[jj*lanes+i];
    endtask

    task automatic cycle(input bit en, input bit vld, input logic [7:0] flip, input bit clr);
        logic [7:0] w, rx, mask;
        exp_t       e;
        int         mism;
        bit         ok, p, r, e_err;
        @(negedge clock);
        mask = (lanes == 8) ? 8'hFF : 8'h01;
        get_word(step, w);
        rx = (w ^ flip) & mask;
        a_en = 1'b0; a_tx = 1'b0; a_rxv = 1'b0; a_clr = 1'b0; a_rxd = 1'b0;
        b_en = 1'b0; b_tx = 1'b0; b_rxv = 1'b0; b_clr = 1'b0; b_rxd = 8'h00;
        if (cur == 0) begin
            a_en = en; a_tx = vld; a_rxv = vld; a_clr = clr; a_rxd = rx[0:0];
        end else begin
            b_en = en; b_tx = vld; b_rxv = vld; b_clr = clr; b_rxd = rx;
        end
        e_err = 1'b0;
        if (CHK && en && vld) begin
            ok = 1'b0;
            for (int k = 1; k <= 9; k++) if (h[h.size()-k]) ok = 1'b1;
            mism = 0;
            for (int i = 0; i < lanes; i++) begin
                r = rx[lanes-1-i];
                p = h[h.size()-9] ^ h[h.size()-5];
                if (r != p) mism++;
                h.push_back(lockd ? p : r);
            end
            while (h.size() > 32) void'(h.pop_front());
            if (!lockd) begin
                if (mism == 0 && ok) good++;
                else                 good = 0;
                if (good == 16) begin lockd = 1'b1; good = 0; badw = 0; end
            end else begin
                if (mism != 0) begin
                    e_err = 1'b1;
                    badw++;
                    cnt = (cnt + mism > maxcnt) ? maxcnt : cnt + mism;
                end else begin
                    badw = 0;
                end
                if (badw == 4) begin lockd = 1'b0; good = 0; badw = 0; end
            end
        end
        if (CHK && clr) cnt = 0;
        if (en && vld) step++;
        get_word(step, w);
        e.dut = cur; e.data = int'(w); e.lock = int'(lockd); e.err = int'(e_err); e.cnt = cnt;
        q.push_back(e);
    endtask

    always @(posedge clock) begin
        #2;
        if (q.size() > 0) begin
            me = q.pop_front();
            if (me.dut == 0) begin
                check("a_data",  int'(a_data), me.data);
                check("a_lock",  int'(a_lock), me.lock);
                check("a_err",   int'(a_err),  me.err);
                check("a_count", int'(a_cnt),  me.cnt);
            end else begin
                check("b_data",  int'(b_data), me.data);
                check("b_lock",  int'(b_lock), me.lock);
                check("b_err",   int'(b_err),  me.err);
                check("b_count", int'(b_cnt),  me.cnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_tx = 1'b0; a_rxv = 1'b0; a_clr = 1'b0; a_rxd = 1'b0;
        b_en = 1'b0; b_tx = 1'b0; b_rxv = 1'b0; b_clr = 1'b0; b_rxd = 8'h00;
        model_reset(0);
        repeat (3) @(negedge clock);
        check("rst_a_data",  int'(a_data), 1);
        check("rst_a_lock",  int'(a_lock), 0);
        check("rst_a_err",   int'(a_err),  0);
        check("rst_a_count", int'(a_cnt),  0);
        check("rst_b_data",  int'(b_data), 8'b11010101);
        check("rst_b_count", int'(b_cnt),  0);
        rst_n = 1'b1;

        // LANES=1: clean loopback must lock within 25 valid words.
        repeat (25) cycle(1'b1, 1'b1, 8'h00, 1'b0);
        @(posedge clock); #3;
        check("lock_within_25", int'(a_lock), int'(CHK));
        repeat (1000) cycle($urandom_range(15, 0) != 0, $urandom_range(3, 0) != 0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'h01, 1'b0);
        repeat (5) cycle(1'b1, 1'b1, 8'h00, 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 8'h01, 1'b0);
        repeat (40) cycle(1'b1, $urandom_range(7, 0) != 0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, (i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'h01, 1'b1);
        repeat (5) cycle(1'b1, 1'b1, 8'h00, 1'b0);
        repeat (30) cycle(1'b1, 1'b1, 8'h00, 1'b0);
        @(posedge clock); #3;

        // Asynchronous reset mid-run must clear everything without a clock edge.
        rst_n = 1'b0;
        #1;
        check("async_rst_a_data",  int'(a_data), 1);
        check("async_rst_a_lock",  int'(a_lock), 0);
        check("async_rst_a_count", int'(a_cnt),  0);
        @(negedge clock);
        rst_n = 1'b1;

        // LANES=8: lock, then random multi-bit corruption with gaps.
        model_reset(1);
        repeat (30) cycle(1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(15, 0) != 0, $urandom_range(3, 0) != 0,
                  ($urandom_range(7, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00, 1'b0);
        end
        cycle(1'b1, 1'b1, 8'h81, 1'b1);
        repeat (20) cycle(1'b1, 1'b1, 8'h00, 1'b0);

        repeat (2) @(posedge clock);
        #3;
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised PRBS generator and self-synchronising checker for the link test path. The generator produces a Fibonacci LFSR sequence of configurable order, emitting LANES bits per enabled cycle. The checker locks onto a received PRBS stream, counts bit errors and reports loss of lock. The block sits between the test-pattern mux and the serializer/deserializer loopback, and is the successor of the fixed 9-bit serial generator.

## Interface

Parameters:
- NB, 9: LFSR length; polynomial x^NB + x^TAP + 1.
- TAP, 5: second feedback tap. Feedback = reg[NB-1] ^ reg[TAP-1].
- SEED, 9'h1AA: generator reset value, NB bits. SEED==0 is replaced by 1.
- LANES, 1: bits produced and checked per enabled cycle, 1..NB.
- LOCK_CNT, 16: consecutive fully-correct received words required to lock.
- LOSS_CNT, 4: consecutive erroneous received words that drop lock.
- ERR_W, 16: error counter width.

Ports:
- clock, in, 1: clock.
- i_reset, in, 1: reset, asynchronous, active-low.
- i_enable, in, 1: global enable; gates both generator and checker.
- i_enb_tx, in, 1: generator step strobe.
- o_data, out, LANES: current generator word; bit LANES-1 is the oldest bit.
- i_rx_data, in, LANES: received word, same bit order as o_data.
- i_rx_valid, in, 1: i_rx_data valid this cycle.
- i_clr_err, in, 1: synchronous clear of o_err_count.
- o_lock, out, 1: checker locked.
- o_err, out, 1: one-cycle pulse when a locked compare had at least one bit error.
- o_err_count, out, ERR_W: saturating bit-error count.

## Operation

- Serial sequence: s_k is reg[NB-1] after k single shifts from SEED, each shift being reg <= {reg[NB-2:0], fb}.
- Generator:
  - o_data[LANES-1-i] = s_{j*LANES+i} at step j. Output is combinational from the register.
  - Each cycle with i_enable && i_enb_tx, the register advances LANES shifts. Otherwise it holds.
- Checker history register H (NB bits) predicts each incoming bit as the feedback of the preceding NB bits.
- Checker states:
  - SEARCH:
    - H shifts in the received bits.
    - A word is good when all LANES predictions match and the history used is non-zero. An all-zero history never counts as a match, so the checker cannot lock on a dead link.
    - The good-word counter increments on each good word and clears on any other valid word.
    - Reaching LOCK_CNT moves to LOCKED and clears both counters.
  - LOCKED:
    - H free-runs on its own predictions; received data is compared only.
    - Each valid word adds its mismatched-bit count to o_err_count, saturating at all-ones.
    - Each erroneous word pulses o_err and increments the bad-word counter. Any good word clears that counter.
    - Reaching LOSS_CNT moves to SEARCH and clears both counters.
- The checker acts only on cycles with i_enable && i_rx_valid.
- i_clr_err has priority over a same-cycle increment; that cycle's errors are discarded. i_clr_err does not affect lock state.
- Reset values:
  - Generator register = SEED, so o_data = its first LANES bits.
  - H = 0, state SEARCH, all counters 0.
  - o_lock = 0, o_err = 0, o_err_count = 0.

## Timing

- Generator: o_data changes on the clock edge that ends an enabled step cycle. Latency is zero from register to output.
- Checker: o_lock, o_err and o_err_count are registered and update on the edge ending the valid cycle that caused the change.
- Lock latency from a clean stream is at most ceil(NB/LANES) + LOCK_CNT valid words.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous); no partial state survives.

## Configuration

- PRBS_CHECKER_EN defined: checker compiled in, behaving as described above.
- PRBS_CHECKER_EN undefined: only the generator exists.
  - o_lock, o_err and o_err_count are tied to 0.
  - i_rx_data, i_rx_valid and i_clr_err are ignored.

## Test plan

- Defaults, LANES=1, i_enable=i_enb_tx=1 after reset -> o_data stream 1,1,0,1,0,1,0,1,0,1,… with period 511; after reset o_data=1 before the first step.
- LANES=8 -> first word 8'b11010101; each following word equals the next 8 bits of the LANES=1 stream.
- Loopback o_data -> i_rx_data, i_rx_valid=1 -> o_lock rises within 25 valid cycles; o_err_count stays 0 for 1000 cycles.
- Locked, flip one rx bit -> o_err pulses exactly one cycle, o_err_count 0->1, o_lock stays 1.
- Locked, invert rx for 4 consecutive words -> o_err_count +4; o_lock falls on the edge after the 4th word; relocks after the stream is restored.
- ERR_W=3, flip one bit in every other word for 20 words -> o_err_count saturates at 7, lock held. Then i_clr_err together with an error -> count 0.
